// File: rtl/lcv_mul_wide_seq.sv
// rtl/lcv_mul_wide_seq.sv - sequential full-width multiplier built on one half-width signed multiply stage
module lcv_mul_wide_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inp_valid,
    output logic                 inp_ready,
    input  logic [WIDTH-1:0]     inp_a,
    input  logic [WIDTH-1:0]     inp_b,
    input  logic                 inp_signed,
    output logic                 outp_valid,
    input  logic                 outp_ready,
    output logic [2*WIDTH-1:0]   outp_data,
    output logic                 outp_busy
);
    localparam int HALF = WIDTH / 2;
    localparam int PW   = 2 * HALF + 2;

    typedef enum logic [1:0] {IDLE, MUL, DRAIN, DONE} state_t;

    state_t                    state;
    logic [WIDTH-1:0]          a_r;
    logic [WIDTH-1:0]          b_r;
    logic                      sgn_r;
    logic [1:0]                idx;
    logic signed [PW-1:0]      prod_r;
    logic [1:0]                shift_r;
    logic                      prod_vld;
    logic [2*WIDTH-1:0]        acc;

    logic signed [HALF:0]      a_lo, a_hi, b_lo, b_hi;
    logic signed [HALF:0]      op_x, op_y;
    logic signed [PW-1:0]      mul_p;
    logic [2*WIDTH-1:0]        part_ext;
    logic [2*WIDTH-1:0]        part_sh;

    // Low halves carry no sign; high halves carry the operand sign only in signed mode.
    always_comb begin
        a_lo = {1'b0, a_r[HALF-1:0]};
        b_lo = {1'b0, b_r[HALF-1:0]};
        a_hi = {sgn_r & a_r[WIDTH-1], a_r[WIDTH-1:HALF]};
        b_hi = {sgn_r & b_r[WIDTH-1], b_r[WIDTH-1:HALF]};
        op_x = idx[1] ? a_hi : a_lo;
        op_y = idx[0] ? b_hi : b_lo;
    end

    assign mul_p = $signed({{(HALF+1){op_x[HALF]}}, op_x})
                 * $signed({{(HALF+1){op_y[HALF]}}, op_y});

    // Shift tag 0/1/2 selects a shift of 0, HALF or WIDTH bits.
    always_comb begin
        part_ext = {{(2*WIDTH-PW){prod_r[PW-1]}}, prod_r};
        case (shift_r)
            2'd0:    part_sh = part_ext;
            2'd1:    part_sh = part_ext << HALF;
            default: part_sh = part_ext << WIDTH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            a_r      <= '0;
            b_r      <= '0;
            sgn_r    <= 1'b0;
            idx      <= 2'd0;
            prod_r   <= '0;
            shift_r  <= 2'd0;
            prod_vld <= 1'b0;
            acc      <= '0;
        end else begin
            if (prod_vld)
                acc <= acc + part_sh;
            case (state)
                IDLE: begin
                    if (inp_valid) begin
                        a_r      <= inp_a;
                        b_r      <= inp_b;
                        sgn_r    <= inp_signed;
                        acc      <= '0;
                        idx      <= 2'd0;
                        prod_vld <= 1'b0;
                        state    <= MUL;
                    end
                end
                MUL: begin
                    prod_r   <= mul_p;
                    shift_r  <= {1'b0, idx[1]} + {1'b0, idx[0]};
                    prod_vld <= 1'b1;
                    idx      <= idx + 2'd1;
                    if (idx == 2'd3)
                        state <= DRAIN;
                end
                DRAIN: begin
                    prod_vld <= 1'b0;
                    state    <= DONE;
                end
                DONE: begin
                    if (outp_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign inp_ready  = (state == IDLE);
    assign outp_valid = (state == DONE);
    assign outp_busy  = (state != IDLE);
    assign outp_data  = acc;
endmodule

// File: tb/tb_lcv_mul_wide_seq.sv
// tb/tb_lcv_mul_wide_seq.sv - directed and back-to-back checks for lcv_mul_wide_seq
module tb_lcv_mul_wide_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inp_valid = 1'b0;
    logic        inp_ready;
    logic [31:0] inp_a = '0;
    logic [31:0] inp_b = '0;
    logic        inp_signed = 1'b0;
    logic        outp_valid;
    logic        outp_ready = 1'b0;
    logic [63:0] outp_data;
    logic        outp_busy;

    int checks = 0;
    int failures = 0;

    lcv_mul_wide_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .inp_valid(inp_valid), .inp_ready(inp_ready),
        .inp_a(inp_a), .inp_b(inp_b), .inp_signed(inp_signed),
        .outp_valid(outp_valid), .outp_ready(outp_ready),
        .outp_data(outp_data), .outp_busy(outp_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic signed [63:0] x, y;
        if (s) begin
            x = $signed({{32{a[31]}}, a});
            y = $signed({{32{b[31]}}, b});
            return x * y;
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    // Issues one operation, checks latency and result, optionally completes the handshake.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [63:0] exp, input logic handshake, input string name);
        int lat;
        @(negedge clk);
        inp_a = a; inp_b = b; inp_signed = s; inp_valid = 1'b1;
        chk({name, "_inp_ready"}, 64'(inp_ready), 64'd1);
        @(posedge clk);
        #1 inp_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (outp_valid) begin
                lat = k - 1;
                break;
            end
        end
        chk({name, "_latency"}, 64'(lat), 64'd5);
        chk({name, "_data"}, outp_data, exp);
        if (handshake) begin
            outp_ready = 1'b1;
            @(posedge clk);
            #1 outp_ready = 1'b0;
            @(negedge clk);
            chk({name, "_post_valid"}, 64'(outp_valid), 64'd0);
            chk({name, "_post_ready"}, 64'(inp_ready), 64'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] expq[$];
        logic [63:0] e;
        int last_acc;
        int n_acc;

        vecs[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001};
        vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h0000000000000001};
        vecs[2] = '{32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000};
        vecs[3] = '{32'hFFFFFFFE, 32'h00000003, 1'b1, 64'hFFFFFFFFFFFFFFFA};
        vecs[4] = '{32'hFFFFFFFE, 32'h00000003, 1'b0, 64'h00000002FFFFFFFA};
        vecs[5] = '{32'h00000007, 32'h00000006, 1'b0, 64'h000000000000002A};
        vecs[6] = '{32'h00000000, 32'hDEADBEEF, 1'b1, 64'h0000000000000000};
        vecs[7] = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h0000000080000000};
        vecs[8] = '{32'h12345678, 32'h00000010, 1'b0, 64'h0000000123456780};
        vecs[9] = '{32'h7FFFFFFF, 32'h80000000, 1'b1, 64'hC000000080000000};

        // Reset state
        #12;
        chk("rst_inp_ready", 64'(inp_ready), 64'd1);
        chk("rst_outp_valid", 64'(outp_valid), 64'd0);
        chk("rst_outp_busy", 64'(outp_busy), 64'd0);
        chk("rst_outp_data", outp_data, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp, 1'b1, $sformatf("vec%0d", i));

        // Backpressure in DONE with a toggling request
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001, 1'b0, "bp");
        for (int c = 0; c < 10; c++) begin
            chk("bp_hold_valid", 64'(outp_valid), 64'd1);
            chk("bp_hold_data", outp_data, 64'hFFFFFFFE00000001);
            chk("bp_inp_ready", 64'(inp_ready), 64'd0);
            inp_valid = ~inp_valid;
            inp_a = 32'(c);
            @(negedge clk);
        end
        inp_valid = 1'b0;
        outp_ready = 1'b1;
        @(posedge clk);
        #1 outp_ready = 1'b0;
        @(negedge clk);
        chk("bp_release_valid", 64'(outp_valid), 64'd0);
        chk("bp_release_busy", 64'(outp_busy), 64'd0);
        @(negedge clk);
        chk("bp_idle_busy", 64'(outp_busy), 64'd0);

        // Asynchronous reset while idx=2
        inp_a = 32'hFFFFFFFF; inp_b = 32'hFFFFFFFF; inp_signed = 1'b0; inp_valid = 1'b1;
        @(posedge clk);
        #1 inp_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("mid_busy", 64'(outp_busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_inp_ready", 64'(inp_ready), 64'd1);
        chk("mid_rst_valid", 64'(outp_valid), 64'd0);
        chk("mid_rst_busy", 64'(outp_busy), 64'd0);
        chk("mid_rst_data", outp_data, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(32'd7, 32'd6, 1'b0, 64'd42, 1'b1, "after_rst");

        // Back-to-back with held handshakes against the reference model
        outp_ready = 1'b1;
        last_acc = -1;
        n_acc = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            inp_valid = (cyc < 180);
            if (outp_valid) begin
                if (expq.size() == 0) begin
                    chk("b2b_unexpected", 64'd1, 64'd0);
                end else begin
                    e = expq.pop_front();
                    chk("b2b_data", outp_data, e);
                end
            end
            if (inp_ready && inp_valid) begin
                if (last_acc >= 0)
                    chk("b2b_interval", 64'(cyc - last_acc), 64'd7);
                last_acc = cyc;
                inp_a = $urandom;
                inp_b = $urandom;
                inp_signed = 1'($urandom_range(0, 1));
                expq.push_back(ref_mul(inp_a, inp_b, inp_signed));
                n_acc++;
            end
        end
        inp_valid = 1'b0;
        outp_ready = 1'b0;
        chk("b2b_drained", 64'(expq.size()), 64'd0);
        chk("b2b_count", 64'(n_acc), 64'd26);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lcv_mul_wide_seq.md
# lcv_mul_wide_seq

Sequencer that computes a full 2·WIDTH-bit product of two WIDTH-bit operands, signed or unsigned, by time-sharing one (HALF+1)×(HALF+1) signed multiply stage with a one-cycle registered output. It issues four half-width partial products in sequence and accumulates them with the correct shifts. It sits beside the DSP multiply-accumulate and ALU blocks as the multi-cycle multiply unit for the execute stage, with valid/ready handshakes on both sides.

## Interface
- WIDTH, 32, operand width; must be even; HALF = WIDTH/2.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous and active-high.
- inp_valid  in  1  operand request valid.
- inp_ready  out  1  block can accept an operand pair.
- inp_a  in  WIDTH  multiplicand.
- inp_b  in  WIDTH  multiplier.
- inp_signed  in  1  1: two's-complement operands; 0: unsigned; sampled at accept.
- outp_valid  out  1  result available.
- outp_ready  in  1  consumer accepts result.
- outp_data  out  2·WIDTH  exact product.
- outp_busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, MUL, DRAIN, DONE.
- IDLE: inp_ready=1. On inp_valid&&inp_ready, latch a, b and signed into operand registers, clear the 2·WIDTH accumulator, set idx=0, and move to MUL.
- Operand split: aL=a[HALF-1:0], aH=a[WIDTH-1:HALF], same for b. Extend each half to HALF+1 bits before multiplying. Low halves are always zero-extended. High halves are sign-extended when signed=1 and zero-extended otherwise.
- Partial schedule by idx: 0: aL·bL, shift 0; 1: aL·bH, shift HALF; 2: aH·bL, shift HALF; 3: aH·bH, shift WIDTH.
- MUL: each cycle, register the (2·HALF+2)-bit signed product of the selected pair into prod_r, together with its shift tag. idx increments each cycle. After idx=3 is issued, move to DRAIN.
- Accumulate: every cycle in which prod_r holds a valid partial, sign-extend prod_r to 2·WIDTH bits, shift it left by its tag, and add it to acc. Addition is modulo 2^(2·WIDTH); the final sum is exact.
- DRAIN: absorb the last partial into acc, then move to DONE.
- DONE: outp_valid=1 and outp_data=acc. Both are held stable until outp_ready. On outp_valid&&outp_ready, move to IDLE.
- In MUL, DRAIN and DONE: inp_ready=0 and inp_valid is ignored. No accept happens in the same cycle as a result handshake.
- Reset mid-operation: all state is discarded, and the block returns to IDLE with acc, prod_r and idx cleared. No partial result is ever presented.

## Timing
- Reset values: state=IDLE, inp_ready=1, outp_valid=0, outp_busy=0, outp_data=0.
- Let E0 be the accept edge. Partials 0..3 are registered at E1..E4 and added to acc at E2..E5. The state is DONE after E5, so outp_valid rises after E5: a latency of 5 cycles.
- If outp_ready is high in the first DONE cycle, the result handshakes at E6 and the next accept can occur at E7. The minimum initiation interval is therefore 7 cycles.
- inp_ready and outp_valid are pure decodes of the registered state, with no combinational path from inp_valid or outp_ready.
- outp_data is registered and does not change while outp_valid=1.

## Test plan
- Unsigned full scale: a=b=0xFFFFFFFF, signed=0 -> outp_data=0xFFFFFFFE00000001, with outp_valid first high 5 cycles after accept.
- Signed negatives: a=b=0xFFFFFFFF, signed=1 -> 0x0000000000000001. Also a=b=0x80000000, signed=1 -> 0x4000000000000000.
- Mixed sign: a=0xFFFFFFFE (−2), b=3, signed=1 -> 0xFFFFFFFFFFFFFFFA. The same operands with signed=0 -> 0x00000002FFFFFFFA.
- Backpressure: outp_ready=0 for 10 cycles in DONE -> outp_valid and outp_data hold, inp_ready=0, and a toggling inp_valid is never accepted. Raising outp_ready gives exactly one handshake, followed by IDLE.
- Reset mid-MUL: assert rst while idx=2 -> outputs return to reset values immediately, without waiting for a clock. After release, a=7, b=6, signed=0 -> 42, with the normal 5-cycle latency.
- Back-to-back: inp_valid held high, outp_ready held high, random operands checked against a 64-bit reference model -> accepts exactly every 7 cycles with all results correct.
